// File: rtl/i2c_led.sv
// I2C write-only slave holding GRB colour bytes for a WS2812-style LED chain, re-sent after
// each write transaction. Define I2C_LED_READBACK_EN to allow reading the buffer back over I2C.
module i2c_led #(
  parameter logic [6:0]  ADDRESS = 7'h4A,
  parameter int unsigned LED_CNT = 3,
  parameter int unsigned T0H     = 4,
  parameter int unsigned T1H     = 8,
  parameter int unsigned TBIT    = 12,
  parameter int unsigned TRES    = 600
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  output logic scl_o,
  input  logic sda_i,
  output logic sda_o,
  output logic led_o
);

  localparam int unsigned NB    = 3 * LED_CNT;
  localparam int unsigned NBITS = 8 * NB;
  localparam int unsigned IW    = $clog2(NB + 1);
  localparam int unsigned BW    = $clog2(NBITS);
  localparam int unsigned CW    = $clog2((TRES > TBIT) ? TRES : TBIT);

  localparam logic [IW-1:0] NB_C      = IW'(NB);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);
  localparam logic [CW-1:0] T0H_C     = CW'(T0H);
  localparam logic [CW-1:0] T1H_C     = CW'(T1H);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] TRES_LAST = CW'(TRES - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StDataAck, StIgnore, StRead, StReadAck
  } i2c_state_e;
  typedef enum logic [1:0] {LedIdle, LedBit, LedRes} led_state_e;

  // [1:0] synchronizer, [2] previous synchronized value for edge detection
  logic [2:0] scl_sr, sda_sr;
  logic       scl_s, sda_s, scl_rise, scl_fall, start, stop;

  i2c_state_e    st_q, st_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sda_q, sda_d, wrote_q, wrote_d, wr_en, trig, addr_hit;
  logic [7:0]    buf_q [NB];
  logic [NBITS-1:0] buf_flat;
`ifdef I2C_LED_READBACK_EN
  logic       rd_q, rd_d;
  logic [7:0] rd_byte;
`endif

  led_state_e       led_st_q, led_st_d;
  logic [NBITS-1:0] shf_q, shf_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             pend_q, pend_d, led_q, led_d;

  assign scl_s    = scl_sr[1];
  assign sda_s    = sda_sr[1];
  assign scl_rise = scl_s & ~scl_sr[2];
  assign scl_fall = ~scl_s & scl_sr[2];
  assign start    = scl_s & scl_sr[2] & sda_sr[2] & ~sda_s;
  assign stop     = scl_s & scl_sr[2] & ~sda_sr[2] & sda_s;
  assign addr_hit = (sh_q[7:1] == ADDRESS);

  assign scl_o = 1'b0;
  assign sda_o = sda_q;
  assign led_o = led_q;

  always_comb begin
    buf_flat = '0;
    for (int i = 0; i < NB; i++) buf_flat[8*(NB-1-i) +: 8] = buf_q[i];
  end

`ifdef I2C_LED_READBACK_EN
  always_comb begin
    rd_byte = 8'hFF;
    for (int i = 0; i < NB; i++) if (idx_q == IW'(i)) rd_byte = buf_q[i];
  end
`endif

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    sda_d   = sda_q;
    wrote_d = wrote_q;
    wr_en   = 1'b0;
    trig    = 1'b0;
`ifdef I2C_LED_READBACK_EN
    rd_d    = rd_q;
`endif
    if (start || stop) begin
      trig    = wrote_q;
      wrote_d = 1'b0;
      sda_d   = 1'b0;
      cnt_d   = '0;
      st_d    = start ? StAddr : StIdle;
`ifdef I2C_LED_READBACK_EN
      rd_d    = 1'b0;
`endif
    end else begin
      case (st_q)
        StAddr, StWrite: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (st_q == StAddr) begin
              if (addr_hit && !sh_q[0]) begin
                sda_d = 1'b1;
                idx_d = '0;
                st_d  = StAddrAck;
`ifdef I2C_LED_READBACK_EN
              end else if (addr_hit) begin
                sda_d = 1'b1;
                idx_d = '0;
                rd_d  = 1'b1;
                st_d  = StAddrAck;
`endif
              end else begin
                st_d = StIgnore;
              end
            end else if (idx_q < NB_C) begin
              wr_en   = 1'b1;
              idx_d   = idx_q + 1'b1;
              wrote_d = 1'b1;
              sda_d   = 1'b1;
              st_d    = StDataAck;
            end else begin
              st_d = StIgnore;
            end
          end
        end
        StAddrAck: if (scl_fall) begin
          cnt_d = '0;
          sda_d = 1'b0;
          st_d  = StWrite;
`ifdef I2C_LED_READBACK_EN
          if (rd_q) begin
            sh_d  = rd_byte;
            sda_d = ~rd_byte[7];
            st_d  = StRead;
          end
`endif
        end
        StDataAck: if (scl_fall) begin
          sda_d = 1'b0;
          cnt_d = '0;
          st_d  = StWrite;
        end
`ifdef I2C_LED_READBACK_EN
        StRead: if (scl_fall) begin
          if (cnt_q == 4'd7) begin
            sda_d = 1'b0;
            cnt_d = '0;
            st_d  = StReadAck;
            if (idx_q != NB_C) idx_d = idx_q + 1'b1;
          end else begin
            sda_d = ~sh_q[6];
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
          end
        end
        // cnt_q == 8 marks that the master acknowledged and wants another byte
        StReadAck: begin
          if (scl_rise) begin
            if (sda_s) st_d = StIgnore;
            else       cnt_d = 4'd8;
          end else if (scl_fall && cnt_q == 4'd8) begin
            sh_d  = rd_byte;
            sda_d = ~rd_byte[7];
            cnt_d = '0;
            st_d  = StRead;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    led_st_d = led_st_q;
    shf_d    = shf_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    pend_d   = pend_q;
    led_d    = 1'b0;
    case (led_st_q)
      LedIdle: if (trig) begin
        shf_d    = buf_flat;
        bit_d    = '0;
        cyc_d    = '0;
        led_st_d = LedBit;
      end
      LedBit: begin
        led_d = (cyc_q < (shf_q[NBITS-1] ? T1H_C : T0H_C));
        if (trig) pend_d = 1'b1;
        if (cyc_q == TBIT_LAST) begin
          cyc_d = '0;
          shf_d = {shf_q[NBITS-2:0], 1'b0};
          if (bit_q == LAST_BIT) led_st_d = LedRes;
          else                   bit_d = bit_q + 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      LedRes: begin
        if (cyc_q == TRES_LAST) begin
          cyc_d = '0;
          if (pend_q || trig) begin
            pend_d   = 1'b0;
            shf_d    = buf_flat;
            bit_d    = '0;
            led_st_d = LedBit;
          end else begin
            led_st_d = LedIdle;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
          if (trig) pend_d = 1'b1;
        end
      end
      default: led_st_d = LedIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sr   <= 3'b111;
      sda_sr   <= 3'b111;
      st_q     <= StIdle;
      cnt_q    <= '0;
      sh_q     <= '0;
      idx_q    <= '0;
      sda_q    <= 1'b0;
      wrote_q  <= 1'b0;
`ifdef I2C_LED_READBACK_EN
      rd_q     <= 1'b0;
`endif
      led_st_q <= LedIdle;
      shf_q    <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      pend_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      scl_sr   <= {scl_sr[1:0], scl_i};
      sda_sr   <= {sda_sr[1:0], sda_i};
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      sda_q    <= sda_d;
      wrote_q  <= wrote_d;
`ifdef I2C_LED_READBACK_EN
      rd_q     <= rd_d;
`endif
      led_st_q <= led_st_d;
      shf_q    <= shf_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      pend_q   <= pend_d;
      led_q    <= led_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NB; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) if (wr_en && idx_q == IW'(i)) buf_q[i] <= sh_q;
    end
  end

endmodule

// File: tb/tb_i2c_led.sv
// Directed bench for i2c_led: drives an I2C master on the pads and decodes the LED waveform.
module tb_i2c_led;
  localparam int Q = 4;   // SCL low half-phase, clk cycles
  localparam int H = 8;   // SCL high phase, clk cycles
  localparam int T0H = 4, T1H = 8, TBIT = 12, TRES = 600;

  logic clk = 1'b0, reset = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic scl_o, sda_o, led_o, sda_line;
  int   checks = 0, errors = 0;

  assign sda_line = sda_m & ~sda_o;

  i2c_led dut (
    .clk   (clk),
    .reset (reset),
    .scl_i (scl_m),
    .scl_o (scl_o),
    .sda_i (sda_line),
    .sda_o (sda_o),
    .led_o (led_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(H);
    sda_m = 1'b0; cyc(H);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(H);
    sda_m = 1'b1; cyc(H);
  endtask

  task automatic clock_bit(input logic b, output logic line);
    sda_m = b; cyc(Q);
    scl_m = 1'b1; cyc(H / 2);
    line = sda_line; cyc(H / 2);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], l);
    clock_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, l);
      d[i] = l;
    end
    clock_bit(nack, l);
  endtask

  task automatic write1(input string tag, input logic [7:0] b);
    logic a;
    i2c_start();
    send_byte(8'h94, a); check({tag, " addr ack"}, 72'(a), 72'(1));
    send_byte(b, a);     check({tag, " data ack"}, 72'(a), 72'(1));
    i2c_stop();
  endtask

  // Decode one frame: widths must be T0H/T1H inside TBIT, then a TRES-long low gap.
  task automatic capture(input string tag, input logic [71:0] exp);
    logic [71:0] got;
    int w, h, l, lim, bad;
    got = '0; bad = 0; w = 0;
    do begin @(negedge clk); w++; end while (led_o !== 1'b1 && w < 4000);
    check({tag, " start"}, 72'(led_o), 72'(1));
    if (led_o !== 1'b1) return;
    for (int b = 0; b < 72; b++) begin
      h = 1;
      @(negedge clk);
      while (led_o === 1'b1 && h < 50) begin h++; @(negedge clk); end
      got[71-b] = (h == T1H);
      if (h != T0H && h != T1H) bad++;
      l = 1;
      if (b < 71) begin
        lim = TBIT - h;
        while (l <= lim + 2) begin
          @(negedge clk);
          if (led_o === 1'b1) break;
          l++;
        end
        if (l != lim) bad++;
      end else begin
        lim = TBIT - h + TRES;
        while (l < lim) begin
          @(negedge clk);
          if (led_o !== 1'b0) break;
          l++;
        end
        if (l < lim) bad++;
      end
    end
    check({tag, " data"}, got, exp);
    check({tag, " timing"}, 72'(bad), 72'(0));
  endtask

  task automatic quiet(input string tag, input int n);
    int hi = 0;
    repeat (n) begin @(negedge clk); if (led_o !== 1'b0) hi++; end
    check(tag, 72'(hi), 72'(0));
  endtask

  initial begin
    logic a, prev;
    logic [7:0] d;
    int rises, w;

    cyc(5);
    check("reset led_o", 72'(led_o), 72'(0));
    check("reset sda_o", 72'(sda_o), 72'(0));
    check("reset scl_o", 72'(scl_o), 72'(0));
    reset = 1'b1;
    cyc(5);
    quiet("idle no frame", 100);

    // Basic two-byte write triggers a full 9-byte frame
    fork
      capture("frame1", {8'h71, 8'hA8, 56'h0});
      begin
        i2c_start();
        send_byte(8'h94, a); check("t1 addr ack", 72'(a), 72'(1));
        send_byte(8'h71, a); check("t1 byte0 ack", 72'(a), 72'(1));
        check("t1 ack released", 72'(sda_o), 72'(0));
        send_byte(8'hA8, a); check("t1 byte1 ack", 72'(a), 72'(1));
        i2c_stop();
      end
    join
    quiet("t1 single frame", 200);

    // Repeated START ends the write and triggers the frame
    fork
      capture("frame2", {8'hA8, 8'hA8, 56'h0});
      begin
        i2c_start();
        send_byte(8'h94, a); check("t2 addr ack", 72'(a), 72'(1));
        send_byte(8'hA8, a); check("t2 byte ack", 72'(a), 72'(1));
        i2c_start();
        i2c_stop();
      end
    join
    quiet("t2 single frame", 1700);

    // Wrong address and read address: no ACK, no buffer change, no frame
    i2c_start();
    send_byte(8'h96, a); check("t3 wrong addr nack", 72'(a), 72'(0));
    send_byte(8'h55, a); check("t3 ignored byte nack", 72'(a), 72'(0));
    send_byte(8'h66, a);
    i2c_stop();
`ifndef I2C_LED_READBACK_EN
    i2c_start();
    send_byte(8'h95, a); check("t3 read addr nack", 72'(a), 72'(0));
    i2c_stop();
`endif
    quiet("t3 no frame", 1600);
    fork
      capture("frame3", {8'h33, 8'hA8, 56'h0});
      write1("t3 rewrite", 8'h33);
    join

    // Overflow: 9 bytes ACKed, 10th NACKed
    fork
      capture("frame4", 72'h010203040506070809);
      begin
        i2c_start();
        send_byte(8'h94, a); check("t4 addr ack", 72'(a), 72'(1));
        for (int i = 1; i <= 10; i++) begin
          send_byte(8'(i), a);
          check($sformatf("t4 ack byte%0d", i), 72'(a), 72'(i <= 9));
        end
        i2c_stop();
      end
    join

    // Reset during the third LED bit
    rises = 0; prev = 1'b0; w = 0;
    fork
      write1("t5 pre", 8'hF0);
      while (rises < 3 && w < 4000) begin
        @(negedge clk); w++;
        if (led_o === 1'b1 && prev === 1'b0) rises++;
        prev = led_o;
      end
    join
    check("t5 third bit reached", 72'(rises), 72'(3));
    check("t5 led high before reset", 72'(led_o), 72'(1));
    #2 reset = 1'b0;
    #2;
    check("t5 led_o cleared", 72'(led_o), 72'(0));
    check("t5 sda_o cleared", 72'(sda_o), 72'(0));
    cyc(3);
    reset = 1'b1;
    quiet("t5 frame aborted", 1600);
    fork
      capture("frame5", {8'h80, 64'h0});
      write1("t5 post", 8'h80);
    join

    // Trigger during a frame is held pending and replayed after TRES
    fork
      begin
        capture("frame6a", {8'h11, 64'h0});
        capture("frame6b", {8'h22, 64'h0});
      end
      begin
        write1("t6 first", 8'h11);
        cyc(100);
        write1("t6 second", 8'h22);
      end
    join
    quiet("t6 no third frame", 200);

`ifdef I2C_LED_READBACK_EN
    fork
      capture("frame7", {8'h71, 64'h0});
      write1("t7 write", 8'h71);
    join
    i2c_start();
    send_byte(8'h95, a); check("t7 read addr ack", 72'(a), 72'(1));
    read_byte(1'b1, d);
    check("t7 read data", 72'(d), 72'(8'h71));
    check("t7 nack released", 72'(sda_o), 72'(0));
    i2c_stop();
    quiet("t7 read no frame", 1600);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
